cache_line_arbiter: RTL and testbench
=====================================

Name: cache_line_arbiter

Overview:
- Shares one physical-memory burst port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache miss/writeback interfaces and main memory.
- Grants one line transaction at a time and splits each 256-bit line into 64-bit beats.
- Returns the assembled line and a single-cycle response to the granted cache.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory data beat width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line. Derived; must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_read  in  1  I-cache line read request
- i_addr  in  32  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line writeback request
- d_addr  in  32  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache transaction complete
- pmem_read  out  1  memory burst read
- pmem_write  out  1  memory burst write
- pmem_addr  out  32  memory line address
- pmem_wdata  out  BEAT_W  current write beat
- pmem_rdata  in  BEAT_W  current read beat
- pmem_resp  in  1  beat accepted/valid

Behaviour:
- Reset rst, synchronous, active-high.
  - On reset: state=IDLE, beat counter=0, last_grant=I.
  - All outputs 0, including i_rdata and d_rdata.
  - Reset mid-burst aborts the transaction: pmem_read/pmem_write low the cycle after rst, no resp issued.
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE: requests are sampled here only.
  - Only I pending -> I_RD.
  - Only D pending -> D_WR if d_write, else D_RD. If d_read and d_write are both high, write wins.
  - Both pending -> grant the side not in last_grant, i.e. alternate under contention.
  - On grant: latch address and d_wdata, clear counter, update last_grant.
- I_RD/D_RD:
  - pmem_read=1 continuously.
  - On each pmem_resp, store pmem_rdata into the line buffer slice [cnt*BEAT_W +: BEAT_W] (beat 0 = bits 63:0), then cnt++.
  - On pmem_resp with cnt==BEATS-1 -> DONE.
- D_WR:
  - pmem_write=1 continuously.
  - pmem_wdata = latched line slice [cnt*BEAT_W +: BEAT_W].
  - Advance on pmem_resp as for reads; last beat -> DONE.
- pmem_addr = latched address with bits [4:0] forced to 0. It is held constant for the whole burst and is 0 in IDLE.
- pmem_read and pmem_write are never high together.
- DONE:
  - Assert i_resp or d_resp (granted side only) for exactly one cycle, then -> IDLE.
  - For reads, the line buffer drives the granted side's rdata. i_rdata/d_rdata hold their last value until that side's next read completes.
  - A D writeback does not change d_rdata.
- Requester contract: keep the request high until resp, and drop it the cycle after resp. The IDLE cycle following DONE then sees the dropped request, so there is no duplicate grant.
- A request deasserted mid-transaction is ignored: the burst completes and resp is still issued.
- Latency with zero-wait memory (pmem_resp every cycle): grant edge -> 4 beat cycles -> resp in the 5th cycle after the request is seen in IDLE.
- Each additional wait cycle on pmem_resp adds one cycle.
- Minimum gap between transactions: one IDLE cycle.
- Beat counter width is log2(BEATS). It wraps to 0 on the last beat.

Test Plan:
- i_read=1, i_addr=0x0000_1234, memory returns beats 0xA0..,0xA1..,0xA2..,0xA3.. with no waits -> pmem_addr=0x0000_1220, pmem_read high 4 cycles, i_resp one cycle later with i_rdata={A3,A2,A1,A0}, d_resp stays 0.
- d_write=1, d_addr=0x8000_0040, d_wdata=256'h{4,3,2,1} beats -> pmem_write high, pmem_wdata sequence 1,2,3,4, d_resp one cycle after the last beat, d_rdata unchanged.
- i_read and d_read asserted together from reset (last_grant=I) -> D served first; I granted in the IDLE cycle after d_resp; two resps, no overlap.
- D issues back-to-back reads while i_read stays high -> grants alternate D,I,D; I never waits more than one D transaction.
- Random 0-3 wait cycles between pmem_resp pulses -> data assembled correctly, pmem_addr stable, resp exactly once per transaction.
- rst pulsed after beat 2 of a D_RD -> pmem_read low the next cycle, no d_resp, cnt=0; a fresh i_read afterwards completes normally.

Source files
------------

// File: rtl/cache_line_arbiter.sv
// Shares one memory burst port between the I-cache (reads) and the D-cache (reads/writebacks).
// One line transaction at a time, split into BEATS beats of BEAT_W bits.
module cache_line_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_d_q, last_d_d;   // 1: D side was granted last
  logic              gnt_d_q, gnt_d_d;     // 1: current transaction belongs to D
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [LINE_W-1:0] lbuf_q, lbuf_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic i_req_s, d_req_s, pick_d_s, last_beat_s, burst_s;

  assign i_req_s     = i_read;
  assign d_req_s     = d_read | d_write;
  assign pick_d_s    = d_req_s & (~i_req_s | ~last_d_q);
  assign last_beat_s = (cnt_q == CNT_W'(BEATS - 1));

  // Arbitration, beat sequencing and line assembly
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    lbuf_d    = lbuf_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req_s | d_req_s) begin
          gnt_d_d  = pick_d_s;
          last_d_d = pick_d_s;
          cnt_d    = '0;
          addr_d   = pick_d_s ? d_addr : i_addr;
          wbuf_d   = d_wdata;
          if (!pick_d_s) begin
            state_d = I_RD;
          end else if (d_write) begin
            state_d = D_WR;
          end else begin
            state_d = D_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      I_RD, D_RD: begin
        if (pmem_resp) begin
          lbuf_d[cnt_q*BEAT_W +: BEAT_W] = pmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          // Publish the completed line together with the DONE cycle
          if (last_beat_s) begin
            state_d = DONE;
            if (state_q == I_RD) begin
              i_rdata_d = lbuf_d;
            end else begin
              d_rdata_d = lbuf_d;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      D_WR: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat_s) begin
            state_d = DONE;
          end else begin
            state_d = D_WR;
          end
        end else begin
          state_d = D_WR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wbuf_q    <= '0;
      lbuf_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      lbuf_q    <= lbuf_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign burst_s    = (state_q == I_RD) | (state_q == D_RD) | (state_q == D_WR);
  assign pmem_read  = (state_q == I_RD) | (state_q == D_RD);
  assign pmem_write = (state_q == D_WR);
  assign pmem_addr  = burst_s ? (addr_q & 32'hFFFF_FFE0) : 32'h0000_0000;
  assign pmem_wdata = (state_q == D_WR) ? wbuf_q[cnt_q*BEAT_W +: BEAT_W] : '0;
  assign i_resp     = (state_q == DONE) & ~gnt_d_q;
  assign d_resp     = (state_q == DONE) & gnt_d_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Randomized bench for cache_line_arbiter: the bench plays both caches and memory and
// predicts every cycle from a transaction-level model (grant rule, beat count, line contents).
module tb_cache_line_arbiter;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write;
  logic [31:0]       i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, i_rdata, d_rdata;
  logic              i_resp, d_resp;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [31:0]       pmem_addr;
  logic [BEAT_W-1:0] pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  cache_line_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 burst, 2 response cycle
  int           m_phase, m_beats, wait_cnt, raise_pct, rst_budget;
  bit           m_side, m_wr, m_last_d, wait_en, drop_en, i_out, d_out;
  logic [31:0]  m_addr;
  logic [255:0] m_line, exp_irdata, exp_drdata;
  bit           order_q[$];

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int b = 0; b < BEATS; b++)
      l[b*BEAT_W +: BEAT_W] = {a & 32'hFFFF_FFE0, 32'hA000_0000 | 32'(b)};
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick(input bit do_rst);
    logic [3:0] exp_bus;
    bit just_i, just_d, pi, pd;
    int kind;
    just_i = 1'b0;
    just_d = 1'b0;
    // outputs expected in the current cycle
    exp_bus = 4'b0000;
    if (m_phase == 1) exp_bus = {~m_wr, m_wr, 2'b00};
    else if (m_phase == 2) exp_bus = {2'b00, ~m_side, m_side};
    check_val("bus", {pmem_read, pmem_write, i_resp, d_resp}, exp_bus);
    if (m_phase == 1) begin
      check_val("addr", pmem_addr, m_addr & 32'hFFFF_FFE0);
      if (m_wr) check_val("wdata", pmem_wdata, m_line[m_beats*BEAT_W +: BEAT_W]);
    end else if (m_phase == 0) begin
      check_val("idle_addr", pmem_addr, 32'h0);
    end
    if (m_phase == 2 && !m_wr) begin
      if (m_side) exp_drdata = m_line;
      else        exp_irdata = m_line;
    end
    check_val("i_rdata", i_rdata, exp_irdata);
    check_val("d_rdata", d_rdata, exp_drdata);
    // requesters: drop after resp, occasional early drop, scramble free inputs, new requests
    if (m_phase == 2) begin
      if (m_side) begin d_read = 1'b0; d_write = 1'b0; d_out = 1'b0; just_d = 1'b1; end
      else        begin i_read = 1'b0; i_out = 1'b0; just_i = 1'b1; end
    end
    if (drop_en && m_phase == 1 && $urandom_range(0, 7) == 0) begin
      if (m_side) begin d_read = 1'b0; d_write = 1'b0; end
      else        i_read = 1'b0;
    end
    if (!d_out || (m_phase == 1 && m_side)) begin d_wdata = rand_line(); d_addr = $urandom(); end
    if (!i_out || (m_phase == 1 && !m_side)) i_addr = $urandom();
    if (!i_out && !just_i && $urandom_range(0, 99) < raise_pct) begin
      i_read = 1'b1; i_addr = $urandom(); i_out = 1'b1;
    end
    if (!d_out && !just_d && $urandom_range(0, 99) < raise_pct) begin
      kind = $urandom_range(0, 2);
      d_read = (kind != 1); d_write = (kind != 0);
      d_addr = $urandom(); d_wdata = rand_line(); d_out = 1'b1;
    end
    // reset, directed or injected after two beats of a D read
    rst = do_rst;
    if (!rst && rst_budget > 0 && m_phase == 1 && m_side && !m_wr && m_beats == 2) begin
      rst = 1'b1;
      rst_budget--;
    end
    if (rst) begin
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; i_out = 1'b0; d_out = 1'b0;
    end
    // memory
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom(), $urandom()};
    if (m_phase == 1 && !rst) begin
      if (wait_cnt == 0) begin
        pmem_resp = 1'b1;
        if (!m_wr) pmem_rdata = m_line[m_beats*BEAT_W +: BEAT_W];
        wait_cnt = wait_en ? $urandom_range(0, 3) : 0;
      end else begin
        wait_cnt--;
      end
    end
    // model advance for the coming edge
    if (rst) begin
      m_phase = 0; m_last_d = 1'b0; exp_irdata = '0; exp_drdata = '0;
    end else begin
      case (m_phase)
        0: begin
          pi = i_read;
          pd = d_read | d_write;
          if (pi || pd) begin
            m_side   = pd && (!pi || !m_last_d);
            m_last_d = m_side;
            m_wr     = m_side && d_write;
            m_addr   = m_side ? d_addr : i_addr;
            m_line   = m_wr ? d_wdata : mem_line(m_addr);
            m_beats  = 0;
            m_phase  = 1;
            order_q.push_back(m_side);
            wait_cnt = wait_en ? $urandom_range(0, 3) : 0;
          end
        end
        1: if (pmem_resp) begin
          m_beats++;
          if (m_beats == BEATS) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ord;
    int bad_pairs;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    m_phase = 0; m_beats = 0; m_last_d = 1'b0; m_side = 1'b0; m_wr = 1'b0; wait_cnt = 0;
    exp_irdata = '0; exp_drdata = '0; i_out = 1'b0; d_out = 1'b0;
    raise_pct = 0; wait_en = 1'b0; drop_en = 1'b0; rst_budget = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_bus", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    check_val("rst_addr", pmem_addr, 32'h0);
    check_val("rst_wdata", pmem_wdata, 64'h0);
    check_val("rst_i_rdata", i_rdata, 256'h0);
    check_val("rst_d_rdata", d_rdata, 256'h0);
    rst = 1'b0;

    // single I read, zero-wait memory
    i_read = 1'b1; i_addr = 32'h0000_1234; i_out = 1'b1;
    repeat (8) tick(1'b0);

    // single D writeback
    d_write = 1'b1; d_addr = 32'h8000_0040; d_out = 1'b1;
    d_wdata = {64'd4, 64'd3, 64'd2, 64'd1};
    repeat (8) tick(1'b0);

    // contention straight out of reset: D first, then I
    tick(1'b1);
    order_q.delete();
    i_read = 1'b1; i_addr = 32'h0000_2000; i_out = 1'b1;
    d_read = 1'b1; d_addr = 32'h0000_3000; d_out = 1'b1;
    repeat (14) tick(1'b0);
    check_val("cont_n", 32'(order_q.size()), 32'd2);
    ord = 8'hFF;
    if (order_q.size() >= 2) ord = {6'b0, order_q[0], order_q[1]};
    check_val("cont_order", ord, 8'b10);

    // both sides requesting continuously: strict alternation
    order_q.delete();
    raise_pct = 100;
    repeat (60) tick(1'b0);
    bad_pairs = 0;
    for (int k = 1; k < order_q.size(); k++)
      if (order_q[k] == order_q[k-1]) bad_pairs++;
    check_val("alt_pairs", 32'(bad_pairs), 32'd0);
    check_val("alt_enough", 32'(order_q.size() >= 8), 32'd1);

    // random traffic with memory waits, early drops and mid-burst resets
    raise_pct = 30; wait_en = 1'b1; drop_en = 1'b1; rst_budget = 3;
    repeat (3000) tick(1'b0);
    check_val("rst_injected", 32'(rst_budget < 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
